// File: rtl/ramb16_s4_arb_pkg.sv
// Shared types and RAMB16 port-B (4096 x 4) geometry for the arbiter slice.
package ramb16_s4_arb_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEPTH  = 4096;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ramb16_s4_rr2.sv
// Two-way round-robin grant; the last-granted pointer lg favours requester 0 after reset.
module ramb16_s4_rr2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic lg;

    // On conflict the requester that was not granted last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && (!req1 || lg)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lg <= 1'b1;
        end else if (gnt0) begin
            lg <= 1'b0;
        end else if (gnt1) begin
            lg <= 1'b1;
        end
    end

endmodule

// File: rtl/ramb16_s4_arb.sv
// Port-B arbiter for a 4096 x 4 block RAM: round-robin between two clients plus a
// full-array clear sweep after reset or on CLR.
module ramb16_s4_arb
    import ramb16_s4_arb_pkg::*;
#(
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] CLEAR_VAL      = 4'h0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] DI0,
    input  logic [DATA_W-1:0] DI1,
    output logic              GNT0,
    output logic              GNT1,
    output logic              DOV0,
    output logic              DOV1,
    output logic [DATA_W-1:0] DO,
    output logic              BUSY,
    output logic              ENB,
    output logic              WEB,
    output logic              SSRB,
    output logic [ADDR_W-1:0] ADDRB,
    output logic [DATA_W-1:0] DIB,
    input  logic [DATA_W-1:0] DOB
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    arb_state_e        state;
    logic [ADDR_W-1:0] cnt;
    logic              serve_en;

    assign serve_en = (state == ST_SERVE) && !RST;

    ramb16_s4_rr2 u_rr2 (
        .clk  (CLK),
        .rst  (RST),
        .en   (serve_en),
        .req0 (REQ0),
        .req1 (REQ1),
        .gnt0 (GNT0),
        .gnt1 (GNT1)
    );

    // FSM, sweep counter and read-valid pipeline; CLR is only honoured while serving.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;
            cnt   <= '0;
            DOV0  <= 1'b0;
            DOV1  <= 1'b0;
        end else begin
            DOV0 <= GNT0 && !WE0;
            DOV1 <= GNT1 && !WE1;
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == LAST_ADDR) begin
                        state <= ST_SERVE;
                    end
                end
                default: begin
                    if (CLR) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    // Port-B mux; the access is issued in the same cycle as the grant.
    always_comb begin
        ENB   = 1'b0;
        WEB   = 1'b0;
        ADDRB = '0;
        DIB   = '0;
        if (!RST) begin
            if (state == ST_CLEAR) begin
                ENB   = 1'b1;
                WEB   = 1'b1;
                ADDRB = cnt;
                DIB   = CLEAR_VAL;
            end else if (GNT0) begin
                ENB   = 1'b1;
                WEB   = WE0;
                ADDRB = ADDR0;
                DIB   = DI0;
            end else if (GNT1) begin
                ENB   = 1'b1;
                WEB   = WE1;
                ADDRB = ADDR1;
                DIB   = DI1;
            end
        end
    end

    assign BUSY = (state == ST_CLEAR);
    assign SSRB = 1'b0;
    assign DO   = DOB;

endmodule

// File: tb/tb_ramb16_s4_arb.sv
// Directed bench for ramb16_s4_arb: two instances (sweep-on-reset and serve-on-reset)
// each attached to a behavioural 4096 x 4 write-first port-B RAM.
module tb_ramb16_s4_arb;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // Instance A: CLEAR_ON_RESET=1, CLEAR_VAL=0
    logic        a_clr, a_req0, a_req1, a_we0, a_we1;
    logic [11:0] a_addr0, a_addr1;
    logic [3:0]  a_di0, a_di1;
    logic        a_gnt0, a_gnt1, a_dov0, a_dov1, a_busy, a_enb, a_web, a_ssrb;
    logic [3:0]  a_do, a_dib, a_dob;
    logic [11:0] a_addrb;

    // Instance B: CLEAR_ON_RESET=0, CLEAR_VAL=F
    logic        b_clr, b_req0, b_req1, b_we0, b_we1;
    logic [11:0] b_addr0, b_addr1;
    logic [3:0]  b_di0, b_di1;
    logic        b_gnt0, b_gnt1, b_dov0, b_dov1, b_busy, b_enb, b_web, b_ssrb;
    logic [3:0]  b_do, b_dib, b_dob;
    logic [11:0] b_addrb;

    ramb16_s4_arb #(.CLEAR_ON_RESET(1'b1), .CLEAR_VAL(4'h0)) dut_a (
        .CLK(CLK), .RST(RST), .CLR(a_clr),
        .REQ0(a_req0), .REQ1(a_req1), .WE0(a_we0), .WE1(a_we1),
        .ADDR0(a_addr0), .ADDR1(a_addr1), .DI0(a_di0), .DI1(a_di1),
        .GNT0(a_gnt0), .GNT1(a_gnt1), .DOV0(a_dov0), .DOV1(a_dov1),
        .DO(a_do), .BUSY(a_busy), .ENB(a_enb), .WEB(a_web), .SSRB(a_ssrb),
        .ADDRB(a_addrb), .DIB(a_dib), .DOB(a_dob)
    );

    ramb16_s4_arb #(.CLEAR_ON_RESET(1'b0), .CLEAR_VAL(4'hF)) dut_b (
        .CLK(CLK), .RST(RST), .CLR(b_clr),
        .REQ0(b_req0), .REQ1(b_req1), .WE0(b_we0), .WE1(b_we1),
        .ADDR0(b_addr0), .ADDR1(b_addr1), .DI0(b_di0), .DI1(b_di1),
        .GNT0(b_gnt0), .GNT1(b_gnt1), .DOV0(b_dov0), .DOV1(b_dov1),
        .DO(b_do), .BUSY(b_busy), .ENB(b_enb), .WEB(b_web), .SSRB(b_ssrb),
        .ADDRB(b_addrb), .DIB(b_dib), .DOB(b_dob)
    );

    // Behavioural RAM port B, write-first; preloaded with 7 so a sweep is visible.
    logic [3:0] mem_a [0:4095];
    logic [3:0] mem_b [0:4095];

    always @(posedge CLK) begin
        if (a_enb) begin
            if (a_web) begin
                mem_a[a_addrb] <= a_dib;
                a_dob <= a_dib;
            end else begin
                a_dob <= mem_a[a_addrb];
            end
        end
        if (b_enb) begin
            if (b_web) begin
                mem_b[b_addrb] <= b_dib;
                b_dob <= b_dib;
            end else begin
                b_dob <= mem_b[b_addrb];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge CLK);
    endtask

    initial begin
        int sweep_bad;
        int busy_bad;
        int gnt_bad;

        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = 4'h7;
            mem_b[i] = 4'h7;
        end
        a_dob = 4'h0;
        b_dob = 4'h0;
        {a_clr, a_req1, a_we0, a_we1, a_addr1, a_di0, a_di1} = '0;
        {b_clr, b_req0, b_req1, b_we0, b_we1, b_addr0, b_addr1, b_di0, b_di1} = '0;
        // Requester 0 read of address 0, held through reset and the sweep
        a_req0  = 1'b1;
        a_addr0 = 12'h000;

        // Reset values
        next_cyc();
        #1;
        check("rst_gnt0", 32'(a_gnt0), 32'd0);
        check("rst_enb", 32'(a_enb), 32'd0);
        check("rst_web_addrb_dib", 32'({a_web, a_addrb, a_dib}), 32'd0);
        check("rst_dov", 32'({a_dov0, a_dov1}), 32'd0);
        check("rst_busy_a", 32'(a_busy), 32'd1);
        check("rst_busy_b", 32'(b_busy), 32'd0);
        check("rst_ssrb", 32'(a_ssrb), 32'd0);

        // Sweep: 4096 cycles of ADDRB=i, WEB=1, DIB=0, no grants
        next_cyc();
        RST = 1'b0;
        #1;
        sweep_bad = 0;
        busy_bad  = 0;
        gnt_bad   = 0;
        for (int i = 0; i < 4096; i++) begin
            if (!(a_enb === 1'b1 && a_web === 1'b1 && a_addrb === 12'(i) && a_dib === 4'h0))
                sweep_bad++;
            if (a_busy !== 1'b1) busy_bad++;
            if (a_gnt0 !== 1'b0 || a_gnt1 !== 1'b0) gnt_bad++;
            next_cyc();
            #1;
        end
        check("sweep_port_b", 32'(sweep_bad), 32'd0);
        check("sweep_busy", 32'(busy_bad), 32'd0);
        check("sweep_no_gnt", 32'(gnt_bad), 32'd0);
        check("sweep_end_busy", 32'(a_busy), 32'd0);
        check("first_serve_gnt0", 32'(a_gnt0), 32'd1);
        check("first_serve_port", 32'({a_enb, a_web, a_addrb}), 32'({1'b1, 1'b0, 12'h000}));
        check("b_serve_gnt0_idle", 32'(b_gnt0), 32'd0);

        next_cyc();
        a_req0 = 1'b0;
        #1;
        check("first_read_dov0", 32'(a_dov0), 32'd1);
        check("first_read_do", 32'(a_do), 32'h0);

        // Write A to 123 by req0, then req1 reads it
        a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 12'h123; a_di0 = 4'hA;
        #1;
        check("wr_gnt0", 32'(a_gnt0), 32'd1);
        check("wr_port", 32'({a_web, a_addrb, a_dib}), 32'({1'b1, 12'h123, 4'hA}));
        next_cyc();
        a_req0 = 1'b0; a_we0 = 1'b0;
        a_req1 = 1'b1; a_we1 = 1'b0; a_addr1 = 12'h123;
        #1;
        check("raw_gnt1", 32'({a_gnt0, a_gnt1}), 32'b01);
        check("wr_no_dov", 32'(a_dov0), 32'd0);
        next_cyc();
        // Req1 writes 3 to 200 to give the two readers distinct data
        a_we1 = 1'b1; a_addr1 = 12'h200; a_di1 = 4'h3;
        #1;
        check("raw_dov1", 32'(a_dov1), 32'd1);
        check("raw_do", 32'(a_do), 32'hA);
        check("wr1_gnt1", 32'(a_gnt1), 32'd1);

        // Continuous contention: both read, grants alternate starting with 0
        next_cyc();
        a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 12'h123;
        a_req1 = 1'b1; a_we1 = 1'b0; a_addr1 = 12'h200;
        #1;
        for (int k = 0; k < 6; k++) begin
            check("rr_gnt", 32'({a_gnt0, a_gnt1}), (k % 2 == 0) ? 32'b10 : 32'b01);
            if (k > 0) begin
                check("rr_dov", 32'({a_dov0, a_dov1}), (k % 2 == 1) ? 32'b10 : 32'b01);
                check("rr_do", 32'(a_do), (k % 2 == 1) ? 32'hA : 32'h3);
            end
            next_cyc();
            if (k == 5) begin
                a_req0 = 1'b0;
                a_req1 = 1'b0;
            end
            #1;
        end
        check("rr_last_dov", 32'({a_dov0, a_dov1}), 32'b01);
        check("rr_last_do", 32'(a_do), 32'h3);

        // CLR coinciding with a read of 010 holding 5
        a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 12'h010; a_di0 = 4'h5;
        next_cyc();
        a_we0 = 1'b0; a_clr = 1'b1;
        #1;
        check("clr_gnt0", 32'(a_gnt0), 32'd1);
        check("clr_busy_same", 32'(a_busy), 32'd0);
        next_cyc();
        a_clr = 1'b0; a_req0 = 1'b0;
        #1;
        check("clr_dov0", 32'(a_dov0), 32'd1);
        check("clr_do", 32'(a_do), 32'h5);
        check("clr_busy", 32'(a_busy), 32'd1);
        check("clr_sweep_start", 32'({a_enb, a_web, a_addrb, a_dib}), 32'({1'b1, 1'b1, 12'h000, 4'h0}));

        // Advance the sweep to counter 2000, then reset mid-sweep
        for (int i = 0; i < 2000; i++) next_cyc();
        a_req0 = 1'b1; a_addr0 = 12'h055;
        #1;
        check("mid_sweep_addr", 32'(a_addrb), 32'd2000);
        RST = 1'b1;
        #1;
        check("rst_mid_ctrl", 32'({a_enb, a_web, a_addrb, a_dib}), 32'd0);
        check("rst_mid_gnt", 32'({a_gnt0, a_gnt1, a_dov0, a_dov1}), 32'd0);
        check("rst_mid_busy", 32'(a_busy), 32'd1);
        check("rst_mid_b_ctrl", 32'({b_enb, b_gnt0, b_busy}), 32'd0);
        next_cyc();
        RST = 1'b0;
        a_req0 = 1'b0;
        #1;
        check("restart_addr", 32'({a_enb, a_web, a_addrb}), 32'({1'b1, 1'b1, 12'h000}));
        next_cyc();
        #1;
        check("restart_step", 32'(a_addrb), 32'd1);

        // Instance B: served right after reset, then CLR sweeps with F
        b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 12'hFFF;
        #1;
        check("b_busy_idle", 32'(b_busy), 32'd0);
        check("b_gnt0", 32'(b_gnt0), 32'd1);
        next_cyc();
        b_req0 = 1'b0; b_clr = 1'b1;
        #1;
        check("b_pre_dov0", 32'(b_dov0), 32'd1);
        check("b_pre_do", 32'(b_do), 32'h7);
        next_cyc();
        b_clr = 1'b0;
        #1;
        check("b_clr_busy", 32'(b_busy), 32'd1);
        check("b_sweep_dib", 32'({b_web, b_dib}), 32'({1'b1, 4'hF}));
        for (int i = 0; i < 4096; i++) next_cyc();
        b_req0 = 1'b1; b_addr0 = 12'hFFF;
        #1;
        check("b_sweep_done", 32'(b_busy), 32'd0);
        check("b_post_gnt0", 32'(b_gnt0), 32'd1);
        next_cyc();
        b_req0 = 1'b0;
        #1;
        check("b_post_dov0", 32'(b_dov0), 32'd1);
        check("b_post_do", 32'(b_do), 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
